// File: rtl/i2c_integration_if.sv
// i2c_integration_if: bus-side outputs of the I2C master integration block.
//   SCL    : I2C clock (push-pull)
//   STATE  : 1 = master has released SDA, 0 = master drives SDA
//   D0..D7 : last good read byte, D0 is the LSB
// master modport drives everything; slave modport observes it.
interface i2c_integration_if;
    logic SCL;
    logic STATE;
    logic D0;
    logic D1;
    logic D2;
    logic D3;
    logic D4;
    logic D5;
    logic D6;
    logic D7;

    modport master (output SCL, STATE, D0, D1, D2, D3, D4, D5, D6, D7);
    modport slave  (input  SCL, STATE, D0, D1, D2, D3, D4, D5, D6, D7);
endinterface

// File: rtl/i2c_integration.sv
// i2c_integration: single-master I2C reader. Repeatedly writes REG_ADDR to
// SLAVE_ADDR, issues a repeated START, reads one byte, NACKs it and STOPs,
// then waits IDLE_CYCLES before the next transaction.
// Ports:
//   CLK_48MHZ : system clock, rising edge
//   EXT_RESET : synchronous active-high reset
//   SDA       : I2C data, driven while STATE=0, high-Z while STATE=1
//   bus       : SCL, STATE, D0..D7 (see i2c_integration_if)
module i2c_integration #(
    parameter int unsigned QUARTER_DIV = 120,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
    parameter logic [7:0]  REG_ADDR    = 8'h00,
    parameter int unsigned IDLE_CYCLES = 48000
) (
    input  logic              CLK_48MHZ,
    input  logic              EXT_RESET,
    inout  wire               SDA,
    i2c_integration_if.master bus
);

    localparam int unsigned QW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
    localparam int unsigned WW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WR_BIT, S_WR_ACK, S_RSTART,
        S_RD_BIT, S_MNACK, S_STOP, S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] q_cnt_q, q_cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          nack_q, nack_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          rel_q, rel_d;

    logic          sda_in;
    logic          q_last;
    logic          slot_end;
    logic          sample;
    logic [7:0]    tx_byte;

    assign SDA    = rel_q ? 1'bz : sda_q;
    assign sda_in = SDA;

    assign bus.SCL   = scl_q;
    assign bus.STATE = rel_q;
    assign bus.D0    = data_q[0];
    assign bus.D1    = data_q[1];
    assign bus.D2    = data_q[2];
    assign bus.D3    = data_q[3];
    assign bus.D4    = data_q[4];
    assign bus.D5    = data_q[5];
    assign bus.D6    = data_q[6];
    assign bus.D7    = data_q[7];

    // State and output registers
    always_ff @(posedge CLK_48MHZ) begin
        if (EXT_RESET) begin
            state_q <= S_IDLE;
            q_cnt_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            wait_q  <= '0;
            nack_q  <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_cnt_q <= q_cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            wait_q  <= wait_d;
            nack_q  <= nack_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            rel_q   <= rel_d;
        end
    end

    // Next-state and next-output logic; outputs follow (state, phase) by one clock
    always_comb begin
        state_d  = state_q;
        q_cnt_d  = q_cnt_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        wait_d   = wait_q;
        nack_d   = nack_q;
        shift_d  = shift_q;
        data_d   = data_q;
        scl_d    = 1'b1;
        sda_d    = 1'b1;
        rel_d    = 1'b0;

        q_last   = (q_cnt_q == QW'(QUARTER_DIV - 1));
        slot_end = q_last && (phase_q == 2'd3);
        sample   = q_last && (phase_q == 2'd2);

        unique case (byte_q)
            2'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
            2'd1:    tx_byte = REG_ADDR;
            default: tx_byte = {SLAVE_ADDR, 1'b1};
        endcase

        // Quarter/phase timebase runs only while a bus slot is active
        if (state_q != S_IDLE && state_q != S_WAIT) begin
            q_cnt_d = q_last ? '0 : q_cnt_q + QW'(1);
            if (q_last) phase_d = phase_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE, S_WAIT: begin
                if (wait_q == WW'(IDLE_CYCLES - 1)) begin
                    state_d = S_START;
                    wait_d  = '0;
                    q_cnt_d = '0;
                    phase_d = '0;
                    nack_d  = 1'b0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_START: begin
                scl_d = (phase_q != 2'd3);
                sda_d = ~phase_q[1];
                if (slot_end) begin
                    state_d = S_WR_BIT;
                    byte_d  = 2'd0;
                    bit_d   = 3'd7;
                end
            end
            S_RSTART: begin
                scl_d = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_d = ~phase_q[1];
                if (slot_end) begin
                    state_d = S_WR_BIT;
                    byte_d  = 2'd2;
                    bit_d   = 3'd7;
                end
            end
            S_WR_BIT: begin
                scl_d = phase_q[1];
                sda_d = tx_byte[bit_q];
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = S_WR_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_WR_ACK: begin
                scl_d = phase_q[1];
                rel_d = 1'b1;
                if (sample && sda_in) nack_d = 1'b1;
                if (slot_end) begin
                    if (nack_q) begin
                        state_d = S_STOP;
                    end else begin
                        unique case (byte_q)
                            2'd0: begin
                                state_d = S_WR_BIT;
                                byte_d  = 2'd1;
                                bit_d   = 3'd7;
                            end
                            2'd1:    state_d = S_RSTART;
                            default: begin
                                state_d = S_RD_BIT;
                                bit_d   = 3'd7;
                            end
                        endcase
                    end
                end
            end
            S_RD_BIT: begin
                scl_d = phase_q[1];
                rel_d = 1'b1;
                if (sample) shift_d = {shift_q[6:0], sda_in};
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = S_MNACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_MNACK: begin
                scl_d = phase_q[1];
                if (slot_end) state_d = S_STOP;
            end
            S_STOP: begin
                scl_d = (phase_q != 2'd0);
                sda_d = phase_q[1];
                if (slot_end) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                    // Only a transaction with all three ACKs publishes its byte
                    if (!nack_q) data_d = shift_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_integration.sv
// tb_i2c_integration: directed bench for i2c_integration with a small
// slave model that ACKs (or NACKs a chosen slot) and returns a set byte.
module tb_i2c_integration;

    localparam int unsigned Q    = 12;
    localparam int unsigned IDLE = 600;
    localparam int unsigned BITC = 4 * Q;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  sda;
    logic [7:0] d;

    i2c_integration_if bus ();

    i2c_integration #(
        .QUARTER_DIV(Q),
        .SLAVE_ADDR (7'h48),
        .REG_ADDR   (8'h00),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .CLK_48MHZ(clk),
        .EXT_RESET(rst),
        .SDA      (sda),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    assign d = {bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};

    int errors = 0;
    int checks = 0;

    // Slave model: n counts finished slave-driven slots since the last STOP
    logic [7:0] slave_data = 8'h00;
    int         nack_slot  = -1;
    int         n          = 0;
    logic       slave_bit;

    always_comb begin
        slave_bit = 1'b1;
        if (n == nack_slot)   slave_bit = 1'b1;
        else if (n <= 2)      slave_bit = 1'b0;
        else if (n <= 10)     slave_bit = slave_data[3'(10 - n)];
    end

    assign sda = bus.STATE ? slave_bit : 1'bz;

    // Bus monitor
    logic        scl_p = 1'b1, sda_p = 1'b1, st_p = 1'b0, rst_p = 1'b1;
    int          cyc = 0;
    logic [63:0] rbits = '0, last_bits = '0;
    int          rcnt = 0, last_cnt = 0;
    int          st_rises = 0, last_rises = 0;
    int          rise_t = 0, period = 0;
    int          n_start = 0, n_stop = 0, n_viol = 0;
    int          start_t = 0, stop_t = 0;

    always @(negedge clk) begin
        cyc   <= cyc + 1;
        scl_p <= bus.SCL;
        sda_p <= sda;
        st_p  <= bus.STATE;
        rst_p <= rst;
        if (rst || rst_p) begin
            rbits    <= '0;
            rcnt     <= 0;
            st_rises <= 0;
            n        <= 0;
        end else begin
            if (!scl_p && bus.SCL) begin
                rbits  <= {rbits[62:0], sda};
                rcnt   <= rcnt + 1;
                rise_t <= cyc;
                if (rcnt == 1) period <= cyc - rise_t;
            end
            if (scl_p && !bus.SCL && st_p) n <= n + 1;
            if (!st_p && bus.STATE) st_rises <= st_rises + 1;
            if ((st_p != bus.STATE) && bus.SCL) n_viol <= n_viol + 1;
            if (scl_p && bus.SCL && (sda_p != sda)) begin
                if (sda_p && !sda) begin
                    n_start <= n_start + 1;
                    start_t <= cyc;
                end else begin
                    n_stop     <= n_stop + 1;
                    stop_t     <= cyc;
                    last_bits  <= rbits;
                    last_cnt   <= rcnt;
                    last_rises <= st_rises;
                    rbits      <= '0;
                    rcnt       <= 0;
                    st_rises   <= 0;
                    n          <= 0;
                end
            end
        end
    end

    // Expected SCL-rise samples of a good transaction returning data
    function automatic logic [37:0] good_bits(input logic [7:0] data);
        return {8'h90, 1'b0, 8'h00, 1'b0, 1'b1, 8'h91, 1'b0, data, 1'b1, 1'b0};
    endfunction

    task automatic wait_stop(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk); #1;
            if (n_stop >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int target, output bit ok, output bit scl_low);
        ok      = 1'b0;
        scl_low = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk); #1;
            if (n_start >= target) begin
                ok = 1'b1;
                break;
            end
            if (bus.SCL !== 1'b1) scl_low = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok, scl_low;
        int t0;
        rst = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.SCL !== 1'b1 || bus.STATE !== 1'b0 || sda !== 1'b1 || d !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: scl=%b state=%b sda=%b d=%h, want 1 0 1 00",
                         i, bus.SCL, bus.STATE, sda, d);
            end
        end
        rst = 1'b0;
        t0  = cyc;
        wait_start(1, ok, scl_low);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_first_start: no START seen, want one after %0d clocks", IDLE);
        end
        checks++;
        if (scl_low !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_scl: SCL went low during idle, want high");
        end
        checks++;
        if (start_t - t0 != int'(IDLE + 2 * Q)) begin
            errors++;
            $display("FAIL reset_start_delay: got %0d, want %0d", start_t - t0, IDLE + 2 * Q);
        end
    endtask

    task automatic test_zero_read();
        bit ok;
        logic [37:0] exp;
        exp = good_bits(8'h00);
        wait_stop(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL zero_stop: STOP not seen");
        end
        checks++;
        if (last_cnt != 38 || last_bits[37:0] !== exp) begin
            errors++;
            $display("FAIL zero_wave: got %0d bits %b, want 38 bits %b", last_cnt, last_bits[37:0], exp);
        end
        checks++;
        if (last_rises != 3) begin
            errors++;
            $display("FAIL zero_state_rises: got %0d, want 3", last_rises);
        end
        checks++;
        if (period != int'(BITC)) begin
            errors++;
            $display("FAIL zero_scl_period: got %0d, want %0d", period, BITC);
        end
        repeat (2 * Q) @(negedge clk);
        #1;
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL zero_data: got %h, want 00", d);
        end
    endtask

    task automatic test_read_a5();
        bit ok;
        logic [37:0] exp;
        exp        = good_bits(8'hA5);
        slave_data = 8'hA5;
        wait_stop(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL a5_stop: STOP not seen");
        end
        checks++;
        if (last_cnt != 38 || last_bits[37:0] !== exp) begin
            errors++;
            $display("FAIL a5_wave: got %0d bits %b, want 38 bits %b", last_cnt, last_bits[37:0], exp);
        end
        repeat (2 * Q - 2) @(negedge clk);
        #1;
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL a5_data_early: got %h before STOP end, want 00", d);
        end
        @(negedge clk); #1;
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data: got %h, want a5", d);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [37:0] exp;
        exp        = good_bits(8'h3C);
        slave_data = 8'h3C;
        wait_stop(3, ok);
        checks++;
        if (!ok || last_cnt != 38 || last_bits[37:0] !== exp) begin
            errors++;
            $display("FAIL b2b_wave: ok=%0d got %0d bits %b, want 38 bits %b",
                     ok, last_cnt, last_bits[37:0], exp);
        end
        repeat (2 * Q) @(negedge clk);
        #1;
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_data: got %h, want 3c", d);
        end
    endtask

    task automatic test_nack();
        bit ok, scl_low;
        int base;
        logic [9:0] exp;
        exp        = {8'h90, 1'b1, 1'b0};
        slave_data = 8'hFF;
        nack_slot  = 0;
        wait_stop(4, ok);
        checks++;
        if (!ok || last_cnt != 10 || last_bits[9:0] !== exp) begin
            errors++;
            $display("FAIL nack_wave: ok=%0d got %0d bits %b, want 10 bits %b",
                     ok, last_cnt, last_bits[9:0], exp);
        end
        checks++;
        if (last_rises != 1) begin
            errors++;
            $display("FAIL nack_state_rises: got %0d, want 1", last_rises);
        end
        nack_slot  = -1;
        slave_data = 8'h5A;
        base       = n_start;
        repeat (2 * Q) @(negedge clk);
        #1;
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL nack_data_held: got %h, want 3c", d);
        end
        wait_start(base + 1, ok, scl_low);
        checks++;
        if (!ok || (start_t - stop_t) != int'(IDLE + 4 * Q)) begin
            errors++;
            $display("FAIL nack_restart: ok=%0d gap %0d, want %0d", ok, start_t - stop_t, IDLE + 4 * Q);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok, scl_low;
        int t0, base;
        logic [37:0] exp;
        exp = good_bits(8'h5A);
        ok  = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk); #1;
            if (rcnt >= 32) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_reach: read bit 4 not reached");
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.SCL !== 1'b1 || bus.STATE !== 1'b0 || sda !== 1'b1 || d !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs: scl=%b state=%b sda=%b d=%h, want 1 0 1 00",
                     bus.SCL, bus.STATE, sda, d);
        end
        repeat (3) @(negedge clk);
        #1;
        rst  = 1'b0;
        t0   = cyc;
        base = n_start;
        wait_start(base + 1, ok, scl_low);
        checks++;
        if (!ok || scl_low || (start_t - t0) != int'(IDLE + 2 * Q)) begin
            errors++;
            $display("FAIL midrst_restart: ok=%0d scl_low=%0d delay %0d, want %0d",
                     ok, scl_low, start_t - t0, IDLE + 2 * Q);
        end
        wait_stop(5, ok);
        checks++;
        if (!ok || last_cnt != 38 || last_bits[37:0] !== exp) begin
            errors++;
            $display("FAIL midrst_wave: ok=%0d got %0d bits %b, want 38 bits %b",
                     ok, last_cnt, last_bits[37:0], exp);
        end
        repeat (2 * Q) @(negedge clk);
        #1;
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_data: got %h, want 5a", d);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (n_viol != 0) begin
            errors++;
            $display("FAIL proto_state_toggle: %0d STATE changes with SCL high, want 0", n_viol);
        end
        checks++;
        if (n_start != 11 || n_stop != 5) begin
            errors++;
            $display("FAIL proto_start_stop: starts=%0d stops=%0d, want 11 5", n_start, n_stop);
        end
    endtask

    initial begin
        test_reset();
        test_zero_read();
        test_read_a5();
        test_back_to_back();
        test_nack();
        test_reset_mid_read();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_integration.md
# i2c_integration

Top-level I2C master integration block. It repeatedly reads one register from a fixed slave over a single-master I2C bus clocked from the 48 MHz system clock. It presents the last successfully read byte on eight parallel pins (D0..D7). A STATE output tells the bus partner, or the board-level bidirectional buffer, when the master has released SDA.

## Interface
- QUARTER_DIV, 120: system clocks per SCL quarter-period; 480 clocks per bit gives 100 kHz SCL.
- SLAVE_ADDR, 7'h48: 7-bit slave address.
- REG_ADDR, 8'h00: register pointer written before each read.
- IDLE_CYCLES, 48000: bus-free clocks between transactions (1 ms).
- CLK_48MHZ  in  1  system clock; all logic on its rising edge.
- EXT_RESET  in  1  synchronous, active-high reset.
- SCL  out  1  I2C clock, push-pull.
- SDA  inout  1  I2C data. Driven push-pull by the master when STATE=0; high-impedance when STATE=1.
- D0..D7  out  1 each  last good read byte; D0 is the LSB.
- STATE  out  1  1 = master released SDA (slave drives it); 0 = master drives SDA.

## Operation
- Transaction sequence:
  - IDLE
  - START
  - address+W (0x90 for the default address)
  - ACK
  - REG_ADDR
  - ACK
  - repeated START
  - address+R (0x91)
  - ACK
  - 8 read bits
  - master NACK (SDA=1)
  - STOP
  - WAIT for IDLE_CYCLES
  - back to START
- FSM states: IDLE, START, WR_BIT, WR_ACK, RSTART, RD_BIT, MNACK, STOP, WAIT.
- Bytes are sent and received MSB first.
- A bit counter of 3 bits selects the bit; a byte index selects the address, register or address+R byte.
- Master-driven bits: STATE=0 and SDA equals the bit value.
- Slave ACK slots and all 8 read bits: STATE=1 and SDA=z.
- SDA is sampled in every STATE=1 slot.
- ACK check: a sampled 1 in any ACK slot is a NACK.
  - The master skips the rest of the transaction, issues STOP and enters WAIT.
  - D0..D7 are not updated.
- The read byte is shifted into a holding register. It is copied to D0..D7 only when STOP completes after all three ACKs were 0.
- D0..D7 are otherwise held.
- The next transaction starts automatically after WAIT. There is no external trigger.

## Timing
- Reset (synchronous, EXT_RESET=1 at a clock edge):
  - SCL=1, SDA driven 1, STATE=0, D0..D7=0.
  - FSM goes to IDLE and all counters are cleared.
  - Reset dominates any bus phase. A transaction in progress is abandoned with no STOP.
- IDLE lasts IDLE_CYCLES after reset release before the first START.
- The quarter counter counts 0..QUARTER_DIV-1. The phase advances when it wraps.
- Bit slot = 4 quarters:
  - q0: SCL=0, SDA/STATE updated at the start of q0.
  - q1: SCL=0.
  - q2: SCL=1.
  - q3: SCL=1.
  - Sampling happens on the last clock of q2.
- SDA and STATE change only while SCL=0. The exceptions are START and STOP.
- START and repeated START, 4 quarters:
  - q0: SDA=1, SCL=0 for repeated START only; for START, SCL=1.
  - q1: SDA=1, SCL=1.
  - q2: SDA=0, SCL=1.
  - q3: SDA=0, SCL=0.
- STOP, 4 quarters:
  - q0: SDA=0, SCL=0.
  - q1: SDA=0, SCL=1.
  - q2: SDA=1, SCL=1.
  - q3: SDA=1, SCL=1.
- STATE rises at q0 of a slave slot and falls at q0 of the next master-driven slot.
- During the read byte, STATE stays 1 across all 8 bits (8×480 clocks).
- D0..D7 update 1 clock after the last STOP quarter ends.
- Full good transaction: 4 bytes × 9 bits + 2 starts + 1 stop = 39 slots = 18720 clocks, plus WAIT.

## Test plan
- Reset: hold EXT_RESET=1 for 80 clocks -> SCL=1, STATE=0, SDA=1, D=0x00 throughout. After release, SCL stays 1 for IDLE_CYCLES.
- Slave holds SDA=0 whenever STATE=1 -> waveform matches the sequence: 0x90, ACK, 0x00, ACK, Sr, 0x91, ACK, 8 read bits, NACK, P. Then D=0x00, and SCL period = 480 clocks.
- Slave model ACKs and returns 0xA5 -> after STOP, D7..D0=10100101. A following transaction returning 0x3C updates D to 0x3C.
- Slave returns 1 in the first ACK slot -> master drives STOP next, D is unchanged, and a new START occurs after IDLE_CYCLES.
- Assert EXT_RESET during read bit 4 -> on the next edge SCL=1, STATE=0, D=0x00. The new transaction starts cleanly after IDLE_CYCLES.
- Protocol check over 5 transactions: SDA never changes while SCL=1 except at START/STOP, and STATE toggles only while SCL=0.
